// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the programmable-flag synchronous FIFO.
package fifo_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  localparam int AF_OFFSET  = 2;
  localparam int AE_DEFAULT = 2;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer bus of the FIFO; master drives requests, slave is the FIFO.
interface fifo_if import fifo_pkg::*; #(
  parameter int         WIDTH = 8,
  parameter int         DEPTH = 32,
  parameter fifo_mode_e MODE  = MODE_STD
);
  logic                      wr_en;
  logic [WIDTH-1:0]          data_in;
  logic                      rd_en;
  logic                      clr_err;
  logic [WIDTH-1:0]          data_out;
  logic                      full;
  logic                      empty;
  logic                      almost_full;
  logic                      almost_empty;
  logic [cnt_w(DEPTH)-1:0]   count;
  logic                      overflow;
  logic                      underflow;
  // Lets the consumer know whether data_out is valid without a read request.
  logic                      fall_through;

  assign fall_through = (MODE == MODE_FWFT);

  modport master (
    output wr_en, data_in, rd_en, clr_err,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow, fall_through
  );

  modport slave (
    input  wr_en, data_in, rd_en, clr_err,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH storage: one write port, one read port that is registered
// in standard mode and combinational in fall-through mode.
module fifo_ram import fifo_pkg::*; #(
  parameter int         WIDTH = 8,
  parameter int         DEPTH = 32,
  parameter fifo_mode_e MODE  = MODE_STD,
  localparam int        PW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  if (MODE == MODE_FWFT) begin : g_fwft
    wire unused_fwft = rst ^ re;
    assign rdata = mem[raddr];
  end else begin : g_std
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)    rdata <= '0;
      else if (re) rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO for any DEPTH >= 2 with optional fall-through read,
// programmable almost flags, occupancy count and sticky error flags.
module fifo_prog import fifo_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - AF_OFFSET,
  parameter int AE_LEVEL = AE_DEFAULT,
  parameter int FWFT     = 0
) (
  input logic   clk,
  input logic   rst,
  fifo_if.slave bus
);

  localparam int              CW       = cnt_w(DEPTH);
  localparam int              PW       = ptr_w(DEPTH);
  localparam fifo_mode_e      MODE     = (FWFT != 0) ? MODE_FWFT : MODE_STD;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   AF_C     = CW'(AF_LEVEL);
  localparam logic [CW-1:0]   AE_C     = CW'(AE_LEVEL);
  localparam logic [PW-1:0]   PTR_LAST = PW'(DEPTH - 1);

  if (DEPTH < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
    $error("fifo_prog: need DEPTH >= 2 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             full, empty, almost_full, almost_empty;
  logic             overflow, underflow;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] ram_q;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign wr_ok = bus.wr_en & ~full;
  assign rd_ok = bus.rd_en & ~empty;

  always_comb begin
    count_nxt = count;
    if (wr_ok && !rd_ok)      count_nxt = count + CW'(1);
    else if (rd_ok && !wr_ok) count_nxt = count - CW'(1);
  end

  // State update: every flag is derived from the next count so it is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      count        <= count_nxt;
      full         <= (count_nxt == DEPTH_C);
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= AF_C);
      almost_empty <= (count_nxt <= AE_C);
      overflow     <= (bus.wr_en & full)  | (overflow  & ~bus.clr_err);
      underflow    <= (bus.rd_en & empty) | (underflow & ~bus.clr_err);
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .MODE  (MODE)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (rd_ok),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  // Fall-through output is forced to zero while empty so reset reads as 0.
  if (MODE == MODE_FWFT) begin : g_out_fwft
    assign bus.data_out = empty ? '0 : ram_q;
  end else begin : g_out_std
    assign bus.data_out = ram_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = almost_full;
  assign bus.almost_empty = almost_empty;
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_prog.sv
// Bench for fifo_prog: directed table on a depth-5 FIFO, hand sequences and
// queue-model random traffic on a depth-32 standard and a depth-6 FWFT FIFO.
module tb_fifo_prog;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  always #5 clk = ~clk;

  fifo_if #(.WIDTH(8), .DEPTH(5),  .MODE(MODE_STD))  if_a ();
  fifo_if #(.WIDTH(8), .DEPTH(32), .MODE(MODE_STD))  if_b ();
  fifo_if #(.WIDTH(8), .DEPTH(6),  .MODE(MODE_FWFT)) if_c ();

  fifo_prog #(.WIDTH(8), .DEPTH(5), .FWFT(0)) u_a (.clk(clk), .rst(rst_a), .bus(if_a));
  fifo_prog #(.WIDTH(8), .DEPTH(32), .AF_LEVEL(30), .AE_LEVEL(2), .FWFT(0))
    u_b (.clk(clk), .rst(rst_b), .bus(if_b));
  fifo_prog #(.WIDTH(8), .DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1))
    u_c (.clk(clk), .rst(rst_c), .bus(if_c));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] ctl;   // {wr_en, rd_en, clr_err}
    logic [7:0] din;
    int         cnt;
    logic [5:0] flg;   // {full, empty, almost_full, almost_empty, overflow, underflow}
    logic [7:0] dout;
  } vec_t;

  vec_t tbl [24];

  logic [7:0] q_b [$];
  logic [7:0] q_c [$];
  logic       ovf_b, unf_b, ovf_c, unf_c;
  logic [7:0] dout_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input int cnt, input logic [5:0] flg);
    return {18'd0, cnt[7:0], flg};
  endfunction

  function automatic vec_t mk(input logic [2:0] ctl, input logic [7:0] din, input int cnt,
                              input logic [5:0] flg, input logic [7:0] dout);
    vec_t v;
    v.ctl = ctl; v.din = din; v.cnt = cnt; v.flg = flg; v.dout = dout;
    return v;
  endfunction

  function automatic logic [31:0] stat_a();
    return st(int'(if_a.count), {if_a.full, if_a.empty, if_a.almost_full,
                                 if_a.almost_empty, if_a.overflow, if_a.underflow});
  endfunction

  function automatic logic [31:0] stat_b();
    return st(int'(if_b.count), {if_b.full, if_b.empty, if_b.almost_full,
                                 if_b.almost_empty, if_b.overflow, if_b.underflow});
  endfunction

  function automatic logic [31:0] stat_c();
    return st(int'(if_c.count), {if_c.full, if_c.empty, if_c.almost_full,
                                 if_c.almost_empty, if_c.overflow, if_c.underflow});
  endfunction

  // Reference for the depth-32 FIFO: a queue, two sticky bits and the last popped word.
  task automatic step_b(input logic w, input logic r, input logic c, input logic [7:0] d,
                        input string tag);
    bit fpre, epre, wacc, racc;
    int n;
    fpre = (q_b.size() == 32);
    epre = (q_b.size() == 0);
    wacc = w && !fpre;
    racc = r && !epre;
    if_b.wr_en = w; if_b.rd_en = r; if_b.clr_err = c; if_b.data_in = d;
    @(posedge clk);
    if (racc) dout_b = q_b.pop_front();
    if (wacc) q_b.push_back(d);
    ovf_b = (w && fpre) || (ovf_b && !c);
    unf_b = (r && epre) || (unf_b && !c);
    #1;
    n = q_b.size();
    check({tag, " status"}, stat_b(), st(n, {n == 32, n == 0, n >= 30, n <= 2, ovf_b, unf_b}));
    check({tag, " data_out"}, {24'd0, if_b.data_out}, {24'd0, dout_b});
  endtask

  // Reference for the depth-6 fall-through FIFO: head of queue is always visible.
  task automatic step_c(input logic w, input logic r, input logic c, input logic [7:0] d,
                        input string tag);
    bit fpre, epre, wacc, racc;
    int n;
    logic [7:0] head;
    fpre = (q_c.size() == 6);
    epre = (q_c.size() == 0);
    wacc = w && !fpre;
    racc = r && !epre;
    if_c.wr_en = w; if_c.rd_en = r; if_c.clr_err = c; if_c.data_in = d;
    @(posedge clk);
    if (racc) void'(q_c.pop_front());
    if (wacc) q_c.push_back(d);
    ovf_c = (w && fpre) || (ovf_c && !c);
    unf_c = (r && epre) || (unf_c && !c);
    #1;
    n = q_c.size();
    check({tag, " status"}, stat_c(), st(n, {n == 6, n == 0, n >= 4, n <= 1, ovf_c, unf_c}));
    if (n > 0) begin
      head = q_c[0];
      check({tag, " data_out"}, {24'd0, if_c.data_out}, {24'd0, head});
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.wr_en = 0; if_a.rd_en = 0; if_a.clr_err = 0; if_a.data_in = '0;
    if_b.wr_en = 0; if_b.rd_en = 0; if_b.clr_err = 0; if_b.data_in = '0;
    if_c.wr_en = 0; if_c.rd_en = 0; if_c.clr_err = 0; if_c.data_in = '0;
    ovf_b = 0; unf_b = 0; dout_b = '0; ovf_c = 0; unf_c = 0;

    tbl[0]  = mk(3'b100, 8'h10, 1, 6'b000100, 8'h00);
    tbl[1]  = mk(3'b100, 8'h11, 2, 6'b000100, 8'h00);
    tbl[2]  = mk(3'b100, 8'h12, 3, 6'b001000, 8'h00);
    tbl[3]  = mk(3'b100, 8'h13, 4, 6'b001000, 8'h00);
    tbl[4]  = mk(3'b100, 8'h14, 5, 6'b101000, 8'h00);
    tbl[5]  = mk(3'b100, 8'hFF, 5, 6'b101010, 8'h00);
    tbl[6]  = mk(3'b010, 8'h00, 4, 6'b001010, 8'h10);
    tbl[7]  = mk(3'b010, 8'h00, 3, 6'b001010, 8'h11);
    tbl[8]  = mk(3'b010, 8'h00, 2, 6'b000110, 8'h12);
    tbl[9]  = mk(3'b010, 8'h00, 1, 6'b000110, 8'h13);
    tbl[10] = mk(3'b010, 8'h00, 0, 6'b010110, 8'h14);
    tbl[11] = mk(3'b100, 8'h20, 1, 6'b000110, 8'h14);
    tbl[12] = mk(3'b100, 8'h21, 2, 6'b000110, 8'h14);
    tbl[13] = mk(3'b100, 8'h22, 3, 6'b001010, 8'h14);
    tbl[14] = mk(3'b010, 8'h00, 2, 6'b000110, 8'h20);
    tbl[15] = mk(3'b010, 8'h00, 1, 6'b000110, 8'h21);
    tbl[16] = mk(3'b010, 8'h00, 0, 6'b010110, 8'h22);
    tbl[17] = mk(3'b010, 8'h00, 0, 6'b010111, 8'h22);
    tbl[18] = mk(3'b001, 8'h00, 0, 6'b010100, 8'h22);
    tbl[19] = mk(3'b110, 8'h30, 1, 6'b000101, 8'h22);
    tbl[20] = mk(3'b110, 8'h31, 1, 6'b000101, 8'h30);
    tbl[21] = mk(3'b011, 8'h00, 0, 6'b010100, 8'h31);
    tbl[22] = mk(3'b011, 8'h00, 0, 6'b010101, 8'h31);
    tbl[23] = mk(3'b001, 8'h00, 0, 6'b010100, 8'h31);

    repeat (2) @(posedge clk);
    #1;
    check("reset A status", stat_a(), st(0, 6'b010100));
    check("reset A data_out", {24'd0, if_a.data_out}, 32'd0);
    check("reset B status", stat_b(), st(0, 6'b010100));
    check("reset B data_out", {24'd0, if_b.data_out}, 32'd0);
    check("reset C status", stat_c(), st(0, 6'b010100));
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    // Directed table: fill, overflow, drain, wrap, underflow, error clear.
    for (int i = 0; i < 24; i++) begin
      {if_a.wr_en, if_a.rd_en, if_a.clr_err} = tbl[i].ctl;
      if_a.data_in = tbl[i].din;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d status", i), stat_a(), st(tbl[i].cnt, tbl[i].flg));
      check($sformatf("vec%0d data_out", i), {24'd0, if_a.data_out}, {24'd0, tbl[i].dout});
    end
    {if_a.wr_en, if_a.rd_en, if_a.clr_err} = 3'b000;

    // Thresholds and simultaneous access on the depth-32 FIFO.
    for (int k = 1; k <= 32; k++) begin
      step_b(1'b1, 1'b0, 1'b0, 8'(k + 64), "fill32");
      if (k == 2)  check("ae still set at 2", 32'(if_b.almost_empty), 32'd1);
      if (k == 3)  check("ae clear at 3", 32'(if_b.almost_empty), 32'd0);
      if (k == 29) check("af clear at 29", 32'(if_b.almost_full), 32'd0);
      if (k == 30) check("af set at 30", 32'(if_b.almost_full), 32'd1);
      if (k == 32) check("full at 32", 32'(if_b.full), 32'd1);
    end
    step_b(1'b1, 1'b1, 1'b0, 8'hEE, "wr+rd full");
    check("wr+rd full count", 32'(if_b.count), 32'd31);
    check("wr+rd full overflow", 32'(if_b.overflow), 32'd1);
    step_b(1'b0, 1'b1, 1'b0, 8'h00, "drain31");
    check("af at 30", 32'(if_b.almost_full), 32'd1);
    step_b(1'b0, 1'b1, 1'b0, 8'h00, "drain30");
    check("af clear at 29", 32'(if_b.almost_full), 32'd0);
    while (q_b.size() > 10) step_b(1'b0, 1'b1, 1'b0, 8'h00, "drain");
    step_b(1'b1, 1'b1, 1'b0, 8'h77, "wr+rd at 10");
    check("wr+rd at 10 count", 32'(if_b.count), 32'd10);
    step_b(1'b0, 1'b0, 1'b1, 8'h00, "clr ovf");
    check("overflow cleared", 32'(if_b.overflow), 32'd0);

    // Asynchronous reset in the middle of traffic.
    while (q_b.size() > 0) step_b(1'b0, 1'b1, 1'b0, 8'h00, "empty");
    step_b(1'b0, 1'b1, 1'b0, 8'h00, "pre-rst underflow");
    for (int k = 0; k < 5; k++) step_b(1'b1, 1'b0, 1'b0, 8'(k + 8'h50), "pre-rst fill");
    #3;
    rst_b = 1'b0;
    #1;
    check("async reset status", stat_b(), st(0, 6'b010100));
    check("async reset data_out", {24'd0, if_b.data_out}, 32'd0);
    q_b.delete(); ovf_b = 0; unf_b = 0; dout_b = '0;
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    step_b(1'b0, 1'b1, 1'b0, 8'h00, "post-rst read");
    check("post-rst underflow", 32'(if_b.underflow), 32'd1);

    // Fall-through: a word written into an empty FIFO shows without a read.
    step_c(1'b1, 1'b0, 1'b0, 8'hA5, "fwft wr");
    check("fwft shows A5", {24'd0, if_c.data_out}, 32'h0000_00A5);
    step_c(1'b0, 1'b0, 1'b0, 8'h00, "fwft hold");
    check("fwft hold A5", {24'd0, if_c.data_out}, 32'h0000_00A5);
    step_c(1'b0, 1'b1, 1'b0, 8'h00, "fwft pop");
    check("fwft empty after pop", 32'(if_c.empty), 32'd1);

    // Random traffic, alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 1500; i++) begin
      int pw;
      pw = ((i / 200) % 2 == 0) ? 75 : 25;
      step_b(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) >= pw),
             1'($urandom_range(0, 15) == 0), 8'($urandom), "rand32");
    end
    for (int i = 0; i < 800; i++) begin
      int pw;
      pw = ((i / 40) % 2 == 0) ? 70 : 30;
      step_c(1'($urandom_range(0, 99) < pw), 1'($urandom_range(0, 99) >= pw),
             1'($urandom_range(0, 15) == 0), 8'($urandom), "randfwft");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
